// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the clocked data memory controller
package mem_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte count touched by a legal access size; illegal size reports a full word.
  function automatic int size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 1;
      SZ_HALF: size_bytes = 2;
      default: size_bytes = 4;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian byte-lane merge and load extension
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        ofs,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] merged,
  output logic [WORD_W-1:0] load
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed byte and half out of the stored word.
  always_comb begin
    lane_b = word[7:0];
    case (ofs)
      2'd0: lane_b = word[7:0];
      2'd1: lane_b = word[15:8];
      2'd2: lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = ofs[1] ? word[31:16] : word[15:0];
  end

  // Merge store data into the addressed lanes and extend the loaded lanes.
  always_comb begin
    merged = word;
    load   = word;
    case (size)
      SZ_BYTE: begin
        case (ofs)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
        load = uns ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        if (ofs[1]) merged[31:16] = wdata[15:0];
        else        merged[15:0]  = wdata[15:0];
        load = uns ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      default: begin
        // Word access ignores the unsigned flag; illegal sizes never reach the array.
        merged = wdata;
        load   = word;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - clocked word-organised data memory with valid/ready ports
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 7,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic              cap_we;
  logic [1:0]        cap_size;
  logic              cap_uns;
  logic [1:0]        cap_ofs;
  logic [AW-1:0]     cap_idx;
  logic [WORD_W-1:0] cap_wdata;
  logic              cap_err;
  logic              req_bad;
  logic              accept;
  logic              resolve;
  logic              rsp_take;
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] st_word;
  logic [WORD_W-1:0] ld_word;
  logic [WORD_W-1:0] mem [DEPTH];

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rd_word   = mem[cap_idx];

  // Classify the incoming request: illegal size, misalignment or out-of-range word index.
  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      SZ_BYTE: req_bad = 1'b0;
      SZ_HALF: req_bad = req_addr[0];
      SZ_WORD: req_bad = |req_addr[1:0];
      default: req_bad = 1'b1;
    endcase
    if (32'(req_addr[ADDR_W-1:2]) >= 32'(DEPTH)) req_bad = 1'b1;
  end

  mem_lane_align u_lane (
    .word   (rd_word),
    .ofs    (cap_ofs),
    .size   (cap_size),
    .uns    (cap_uns),
    .wdata  (cap_wdata),
    .merged (st_word),
    .load   (ld_word)
  );

  // Next-state logic. Every accepted request passes through WAIT; the array
  // access (or error report) happens on the edge where the counter is 0, which
  // gives a latency of 1+WAIT_CYCLES edges, and exactly one edge for errors.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    resolve    = 1'b0;
    rsp_take   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          resolve    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_take   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, wait counter, request capture and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_size  <= SZ_BYTE;
      cap_uns   <= 1'b0;
      cap_ofs   <= 2'd0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_err   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        cap_we    <= req_we;
        cap_size  <= req_size;
        cap_uns   <= req_unsigned;
        cap_ofs   <= req_addr[1:0];
        cap_idx   <= req_addr[AW+1:2];
        cap_wdata <= req_wdata;
        cap_err   <= req_bad;
        cnt       <= req_bad ? 4'd0 : 4'(WAIT_CYCLES);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (resolve) begin
        rsp_err   <= cap_err;
        rsp_rdata <= (cap_err || cap_we) ? '0 : ld_word;
      end else if (rsp_take) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
    end
  end

  // Storage array: read-modify-write commit of a legal store; contents are never reset.
  always_ff @(posedge clk) begin
    if (resolve && cap_we && !cap_err) mem[cap_idx] <= st_word;
  end

endmodule
